// File: rtl/inst_sram_pkg.sv
// Shared constants for the instruction SRAM responder and its storage bank.
package inst_sram_pkg;

  localparam int          ADDR_W_DEFAULT    = 16;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1c000000;
  localparam int          WORD_W            = 32;
  localparam int          BYTES             = WORD_W / 8;
  // Driven on rdata after reset and after an out-of-range access.
  localparam logic [WORD_W-1:0] RDATA_RESET = '0;

endpackage

// File: rtl/inst_sram_bank.sv
// Word-addressed byte-lane storage with synchronous read; the read port returns
// the pre-write word by default, or the merged word when INST_SRAM_WRITE_FIRST_EN is defined.
module inst_sram_bank
  import inst_sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BYTES-1:0]  we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  // One narrow array per byte lane so each lane maps onto its own RAM write enable.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [2**ADDR_W];
    logic [7:0] lane_q_reg;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[gi]) begin
          lane_mem[idx] <= wdata[8*gi +: 8];
        end
`ifdef INST_SRAM_WRITE_FIRST_EN
        lane_q_reg <= we[gi] ? wdata[8*gi +: 8] : lane_mem[idx];
`else
        lane_q_reg <= lane_mem[idx];
`endif
      end
    end

    assign rdata[8*gi +: 8] = lane_q_reg;
  end

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder: address decode, fault reporting, read-data hold and
// access counters around inst_sram_bank. Write read-back policy set by INST_SRAM_WRITE_FIRST_EN.
module inst_sram_responder
  import inst_sram_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_en,
  input  logic [BYTES-1:0]  inst_sram_we,
  input  logic [31:0]       inst_sram_addr,
  input  logic [WORD_W-1:0] inst_sram_wdata,
  output logic [WORD_W-1:0] inst_sram_rdata,
  output logic              inst_sram_rvalid,
  output logic              inst_sram_err,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  logic [31:0]       offset;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              misaligned;
  logic              accept;
  logic              is_read;
  logic              bank_en;
  logic [WORD_W-1:0] bank_rdata;

  logic              rvalid_reg;
  logic              err_reg;
  logic              blank_reg;
  logic [31:0]       rd_cnt_reg;
  logic [31:0]       rd_cnt_next;
  logic [31:0]       wr_cnt_reg;
  logic [31:0]       wr_cnt_next;

  assign offset     = inst_sram_addr - BASE_ADDR;
  assign idx        = offset[ADDR_W+1:2];
  assign in_range   = (offset[31:ADDR_W+2] == '0);
  // BASE_ADDR is word aligned, so the offset low bits equal the address low bits.
  assign misaligned = |offset[1:0];
  assign accept     = inst_sram_en & ~reset;
  assign is_read    = (inst_sram_we == '0);
  assign bank_en    = accept & in_range;

  inst_sram_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (inst_sram_we),
    .idx   (idx),
    .wdata (inst_sram_wdata),
    .rdata (bank_rdata)
  );

  always_comb begin
    rd_cnt_next = rd_cnt_reg;
    wr_cnt_next = wr_cnt_reg;
    if (bank_en) begin
      if (is_read) begin
        rd_cnt_next = rd_cnt_reg + 32'd1;
      end else begin
        wr_cnt_next = wr_cnt_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      blank_reg  <= 1'b1;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      rvalid_reg <= accept & is_read;
      err_reg    <= accept & (~in_range | misaligned);
      // The bank output register only moves on in-range accesses, so it holds
      // the last word by itself; blank_reg masks it after reset or a miss.
      if (accept) begin
        blank_reg <= ~in_range;
      end
      rd_cnt_reg <= rd_cnt_next;
      wr_cnt_reg <= wr_cnt_next;
    end
  end

  assign inst_sram_rdata  = blank_reg ? RDATA_RESET : bank_rdata;
  assign inst_sram_rvalid = rvalid_reg;
  assign inst_sram_err    = err_reg;
  assign rd_cnt           = rd_cnt_reg;
  assign wr_cnt           = wr_cnt_reg;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Randomized scoreboard bench for inst_sram_responder against a word-level memory model.
module tb_inst_sram_responder;

  localparam int          ADDR_W = 16;
  localparam logic [31:0] BASE   = 32'h1c000000;

  logic        clk;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_rvalid;
  logic        inst_sram_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  inst_sram_responder #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_we     (inst_sram_we),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_rdata  (inst_sram_rdata),
    .inst_sram_rvalid (inst_sram_rvalid),
    .inst_sram_err    (inst_sram_err),
    .rd_cnt           (rd_cnt),
    .wr_cnt           (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        known;
    logic        rvalid;
    logic        err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: sparse word memory plus architectural output state.
  logic [31:0] model_mem [int unsigned];
  logic [31:0] m_rdata;
  logic        m_known;
  logic [31:0] m_rd;
  logic [31:0] m_wr;

  int vectors = 0;
  int miscompares = 0;
  bit driver_done = 0;

  task automatic drive(input string tag, input logic rst, input logic en,
                       input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] off;
    logic [31:0] old_w;
    logic [31:0] nw;
    logic        inr;
    logic        old_known;
    logic        nw_known;
    int unsigned widx;
    reset = rst;
    inst_sram_en = en;
    inst_sram_we = we;
    inst_sram_addr = addr;
    inst_sram_wdata = wdata;
    e.rvalid = 1'b0;
    e.err = 1'b0;
    if (rst) begin
      m_rdata = 32'h0;
      m_known = 1'b1;
      m_rd = 32'h0;
      m_wr = 32'h0;
    end else if (en) begin
      off = addr - BASE;
      inr = (off < (32'd4 << ADDR_W));
      e.rvalid = (we == 4'h0);
      e.err = !inr || (addr[1:0] != 2'b00);
      if (!inr) begin
        m_rdata = 32'h0;
        m_known = 1'b1;
      end else begin
        widx = off >> 2;
        old_known = model_mem.exists(widx);
        old_w = old_known ? model_mem[widx] : 32'h0;
        if (we == 4'h0) begin
          m_rdata = old_w;
          m_known = old_known;
          m_rd = m_rd + 1;
        end else begin
          nw = old_w;
          for (int b = 0; b < 4; b++) begin
            if (we[b]) nw[8*b +: 8] = wdata[8*b +: 8];
          end
          nw_known = old_known || (we == 4'hf);
          if (nw_known) model_mem[widx] = nw;
`ifdef INST_SRAM_WRITE_FIRST_EN
          m_rdata = nw;
          m_known = nw_known;
`else
          m_rdata = old_w;
          m_known = old_known;
`endif
          m_wr = m_wr + 1;
        end
      end
    end
    e.tag = tag;
    e.rdata = m_rdata;
    e.known = m_known;
    e.rd_cnt = m_rd;
    e.wr_cnt = m_wr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every cycle's outputs are checked against the oldest pending expectation.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        bad = 0;
        if (e.known && inst_sram_rdata !== e.rdata) begin
          $display("FAIL %s rdata: got %08h expected %08h", e.tag, inst_sram_rdata, e.rdata);
          bad = 1;
        end
        if (inst_sram_rvalid !== e.rvalid) begin
          $display("FAIL %s rvalid: got %b expected %b", e.tag, inst_sram_rvalid, e.rvalid);
          bad = 1;
        end
        if (inst_sram_err !== e.err) begin
          $display("FAIL %s err: got %b expected %b", e.tag, inst_sram_err, e.err);
          bad = 1;
        end
        if (rd_cnt !== e.rd_cnt) begin
          $display("FAIL %s rd_cnt: got %0d expected %0d", e.tag, rd_cnt, e.rd_cnt);
          bad = 1;
        end
        if (wr_cnt !== e.wr_cnt) begin
          $display("FAIL %s wr_cnt: got %0d expected %0d", e.tag, wr_cnt, e.wr_cnt);
          bad = 1;
        end
        if (bad) miscompares++;
        $display("%s: rdata=%08h rvalid=%b err=%b rd=%0d wr=%0d", e.tag, inst_sram_rdata,
                 inst_sram_rvalid, inst_sram_err, rd_cnt, wr_cnt);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    int          r;
    // Reset, then store a marker that a later reset-time write must not overwrite.
    drive("rst", 1, 0, 4'h0, BASE, 32'h0);
    drive("wr_marker", 0, 1, 4'hf, BASE, 32'h55AA55AA);
    for (int i = 0; i < 3; i++) drive("rst_req", 1, 1, 4'hf, BASE, 32'hCAFEF00D);
    drive("rd_after_rst", 0, 1, 4'h0, BASE, 32'h0);
    // Byte-enable merge.
    drive("wr_full", 0, 1, 4'hf, BASE + 32'h10, 32'h11223344);
    drive("wr_byte1", 0, 1, 4'b0010, BASE + 32'h10, 32'h0000AA00);
    drive("rd_merge", 0, 1, 4'h0, BASE + 32'h10, 32'h0);
    // Hold while idle.
    drive("rd_base", 0, 1, 4'h0, BASE, 32'h0);
    for (int i = 0; i < 5; i++) drive("idle_hold", 0, 0, 4'h0, 32'h0, 32'h0);
    // Out-of-range on both sides, then a misaligned in-range read.
    drive("rd_below", 0, 1, 4'h0, 32'h1bfffffc, 32'h0);
    drive("rd_above", 0, 1, 4'h0, BASE + (32'd4 << ADDR_W), 32'h0);
    drive("wr_above", 0, 1, 4'hf, BASE + (32'd4 << ADDR_W), 32'h12345678);
    drive("rd_misalign", 0, 1, 4'h0, BASE + 32'h12, 32'h0);
    // Write read-back policy, then write-then-read of the same word.
    drive("wr_zero", 0, 1, 4'hf, BASE + 32'h20, 32'h0);
    drive("wr_policy", 0, 1, 4'hf, BASE + 32'h20, 32'hDEADBEEF);
    drive("wr_part", 0, 1, 4'b1000, BASE + 32'h20, 32'h5A000000);
    drive("rd_b2b", 0, 1, 4'h0, BASE + 32'h20, 32'h0);
    drive("rd_b2b", 0, 1, 4'h0, BASE + 32'h10, 32'h0);
    // Initialise a 16-word window so random reads have defined data.
    for (int i = 0; i < 16; i++) drive("init", 0, 1, 4'hf, BASE + 4*i, $urandom);
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      a = BASE + 4 * $urandom_range(0, 15);
      if (r < 10) a = a + $urandom_range(1, 3);
      else if (r < 15) a = BASE - 4 * $urandom_range(1, 8);
      else if (r < 20) a = BASE + (32'd4 << ADDR_W) + 4 * $urandom_range(0, 8);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 99) < 2)
        drive("rnd_rst", 1, $urandom_range(0, 1), w, a, $urandom);
      else
        drive("rnd", 0, ($urandom_range(0, 99) < 80), w, a, $urandom);
    end
    drive("idle_end", 0, 0, 4'h0, 32'h0, 32'h0);
    driver_done = 1;
  end

  initial begin
    wait (driver_done);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_sram_responder.md
# inst_sram_responder

Responder end of the instruction SRAM interface: accepts single-cycle requests from the fetch stage (en/we/addr/wdata) and returns the read word one cycle later on inst_sram_rdata. Backs requests with a word-addressed on-chip array, supports byte-enable writes for test loading, holds read data stable between requests, and reports faulting accesses and access counts. Sits between the IF stage and the instruction memory in the core top level.

## Interface
- ADDR_W, 16, word-index width; array depth is 2^ADDR_W words
- BASE_ADDR, 32'h1c000000, byte address of word 0
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- inst_sram_en  input  1  request strobe; sampled every posedge
- inst_sram_we  input  4  byte write enables; 4'b0 = read
- inst_sram_addr  input  32  byte address
- inst_sram_wdata  input  32  write data, byte i on bits [8i+7:8i]
- inst_sram_rdata  output  32  read data, registered
- inst_sram_rvalid  output  1  high for the one cycle after an accepted read
- inst_sram_err  output  1  high for the one cycle after a faulting request
- rd_cnt  output  32  accepted in-range reads since reset
- wr_cnt  output  32  accepted in-range writes since reset

## Operation
- Request accepted at a posedge when en=1 and reset=0; no back-pressure, one request per cycle.
- Offset = addr - BASE_ADDR (32-bit modular); word index = offset[ADDR_W+1:2]; in range iff offset[31:ADDR_W+2] == 0.
- addr[1:0] ignored for indexing; nonzero addr[1:0] sets err for the following cycle, access still performed.
- Out-of-range: no array read/write, rdata <= 0, err <= 1, counters unchanged; rvalid follows read/write type as normal.
- Read (we==0, in range): rdata <= mem[idx]; rvalid <= 1; rd_cnt += 1.
- Write (we!=0, in range): mem[idx] byte i <= wdata byte i where we[i]=1; wr_cnt += 1; rvalid <= 0; rdata per Configuration.
- No request (en=0): rdata holds its last value, rvalid <= 0, err <= 0 — fetch relies on the held word while stalled.
- Counters wrap modulo 2^32.
- Array contents are not reset; only the registered outputs and counters are.

## Timing
- Reset: rdata=0, rvalid=0, err=0, rd_cnt=0, wr_cnt=0 after the first posedge with reset=1; a request presented during reset is discarded, including array writes.
- Read latency: exactly 1 cycle; request at edge N, data visible after edge N, stable until the next accepted request.
- Back-to-back reads at edges N, N+1 return mem[a0] then mem[a1] on consecutive cycles.
- Write then read of the same word on consecutive edges returns merged data.
- err and rvalid are single-cycle pulses, never asserted during or directly after reset.

## Configuration
- INST_SRAM_WRITE_FIRST_EN defined: on a write, rdata <= the merged post-write word (write-first).
- Undefined: on a write, rdata <= the pre-write word (read-first).
- rvalid stays 0 after writes in both builds.

## Structure
- Package inst_sram_pkg: BASE_ADDR and ADDR_W defaults, WORD_W=32, BYTES=4, reset value of rdata.
- Sub-module inst_sram_bank: 2^ADDR_W x 32 array, byte-enable write, synchronous read, read-first/write-first selected by the macro. Top holds address decode, error, output hold and counters.

## Test plan
- Reset 3 cycles with en=1, we=4'hf, addr=0x1c000000 -> rdata=0, counters=0, subsequent read of 0x1c000000 does not return the wdata.
- Write 0x11223344 we=4'hf then we=4'b0010 wdata=0x0000AA00 to 0x1c000010, read -> rdata=0x1122AA44 one cycle later, rvalid=1, wr_cnt=2, rd_cnt=1.
- Read 0x1c000000 then en=0 for 5 cycles -> rdata held constant, rvalid only in first cycle.
- Read 0x1bfffffc (below base) and 0x1c000000+4*2^ADDR_W -> err pulse, rdata=0, rd_cnt unchanged.
- Read 0x1c000012 -> err pulse, rdata = word at 0x1c000010.
- Write 0xDEADBEEF over 0x0 at 0x1c000020 -> rdata next cycle 0xDEADBEEF with INST_SRAM_WRITE_FIRST_EN, 0x0 without.
